// File: rtl/cvae_io_pkg.sv
// Shared types and defaults for the CVAE host-side I/O controller.
// Optional cycle counter is enabled by defining CVAE_IO_PERF_EN.
package cvae_io_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } io_state_e;

    localparam int DEF_DATA_WIDTH  = 32;
    localparam int DEF_ADDR_WIDTH  = 16;
    localparam int DEF_STATE_WORDS = 13;
    localparam int DEF_GOAL_WORDS  = 6;
    localparam int DEF_Z_WORDS     = 4;
    localparam int DEF_MAX_SEQ     = 59;
    localparam int DEF_SEQ_W       = 6;

    // Number of words in the post-start initial-data burst.
    function automatic int burst_len(input int state_words, input int goal_words,
                                     input int z_words);
        return state_words + goal_words + z_words;
    endfunction

endpackage

// File: rtl/cvae_io_wr_seq.sv
// State SRAM write sequencer: auto-incrementing write pointer, intra-vector
// word counter, seq_lens/overflow tracking and the registered SRAM port.
// Load-phase writes come in with an explicit address; run-phase writes use
// the internal pointer, which starts right after the initial state vector.
module cvae_io_wr_seq
    import cvae_io_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int STATE_WORDS = DEF_STATE_WORDS,
    parameter int MAX_SEQ     = DEF_MAX_SEQ,
    parameter int SEQ_W       = DEF_SEQ_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  ld_we,
    input  logic [ADDR_WIDTH-1:0] ld_addr,
    input  logic [DATA_WIDTH-1:0] ld_data,
    input  logic                  run_we,
    input  logic [DATA_WIDTH-1:0] run_data,
    output logic                  sram_wea,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [DATA_WIDTH-1:0] sram_wdata,
    output logic [SEQ_W-1:0]      seq_lens,
    output logic                  overflow
);

    localparam int VC_W = $clog2(STATE_WORDS + 1);

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [VC_W-1:0]       vec_cnt;
    logic                  full;
    logic                  run_acc;
    logic                  vec_last;

    // Capacity reached: everything past MAX_SEQ complete vectors is dropped.
    assign full     = (seq_lens == SEQ_W'(MAX_SEQ));
    assign run_acc  = run_we && !full;
    assign vec_last = (vec_cnt == VC_W'(STATE_WORDS - 1));

    // Write pointer, intra-vector counter, completed-vector count, overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= ADDR_WIDTH'(STATE_WORDS);
            vec_cnt  <= '0;
            seq_lens <= '0;
            overflow <= 1'b0;
        end else if (clr) begin
            wr_ptr   <= ADDR_WIDTH'(STATE_WORDS);
            vec_cnt  <= '0;
            seq_lens <= '0;
            overflow <= 1'b0;
        end else if (run_we) begin
            if (full) begin
                overflow <= 1'b1;
            end else begin
                wr_ptr <= wr_ptr + 1'b1;
                if (vec_last) begin
                    vec_cnt  <= '0;
                    seq_lens <= seq_lens + 1'b1;
                end else begin
                    vec_cnt <= vec_cnt + 1'b1;
                end
            end
        end
    end

    // Registered SRAM port; addr/wdata hold their last value between writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sram_wea   <= 1'b0;
            sram_addr  <= '0;
            sram_wdata <= '0;
        end else begin
            sram_wea <= ld_we || run_acc;
            if (ld_we) begin
                sram_addr  <= ld_addr;
                sram_wdata <= ld_data;
            end else if (run_acc) begin
                sram_addr  <= wr_ptr;
                sram_wdata <= run_data;
            end
        end
    end

endmodule

// File: rtl/cvae_io_ctrl.sv
// CVAE host-side I/O controller: run FSM, initial-burst capture banks
// (state/goal/latent) and the state SRAM write sequencer.
// Define CVAE_IO_PERF_EN to add the saturating cycle_count output.
module cvae_io_ctrl
    import cvae_io_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int STATE_WORDS = DEF_STATE_WORDS,
    parameter int GOAL_WORDS  = DEF_GOAL_WORDS,
    parameter int Z_WORDS     = DEF_Z_WORDS,
    parameter int MAX_SEQ     = DEF_MAX_SEQ,
    parameter int SEQ_W       = DEF_SEQ_W
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              start,
    input  logic                              init_valid,
    input  logic [DATA_WIDTH-1:0]             init_data,
    output logic [STATE_WORDS*DATA_WIDTH-1:0] state_vec,
    output logic [GOAL_WORDS*DATA_WIDTH-1:0]  goal_vec,
    output logic [Z_WORDS*DATA_WIDTH-1:0]     z_vec,
    output logic                              load_done,
    input  logic                              st_valid,
    input  logic [DATA_WIDTH-1:0]             st_data,
    input  logic                              core_done,
    output logic                              sram_state_wea,
    output logic [ADDR_WIDTH-1:0]             sram_state_addr,
    output logic [DATA_WIDTH-1:0]             sram_state_wdata,
    output logic [SEQ_W-1:0]                  seq_lens,
    output logic                              overflow,
    output logic                              finish
`ifdef CVAE_IO_PERF_EN
    ,
    output logic [31:0]                       cycle_count
`endif
);

    localparam int BURST = burst_len(STATE_WORDS, GOAL_WORDS, Z_WORDS);
    localparam int WC_W  = $clog2(BURST + 1);

    io_state_e             state;
    logic [WC_W-1:0]       word_cnt;
    logic                  ld_acc;
    logic                  ld_we;
    logic                  run_we;
    logic                  clr;
    logic [ADDR_WIDTH-1:0] ld_addr;

    logic [DATA_WIDTH-1:0] st_q [STATE_WORDS];
    logic [DATA_WIDTH-1:0] gl_q [GOAL_WORDS];
    logic [DATA_WIDTH-1:0] z_q  [Z_WORDS];

    assign ld_acc  = (state == LOAD) && init_valid;
    assign ld_we   = ld_acc && (word_cnt < WC_W'(STATE_WORDS));
    assign run_we  = (state == RUN) && st_valid;
    assign clr     = start && ((state == IDLE) || (state == DONE));
    assign ld_addr = ADDR_WIDTH'(word_cnt);

    // Run FSM with registered load_done pulse and finish level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            word_cnt  <= '0;
            load_done <= 1'b0;
            finish    <= 1'b0;
        end else begin
            load_done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state    <= LOAD;
                        word_cnt <= '0;
                        finish   <= 1'b0;
                    end
                end
                LOAD: begin
                    if (init_valid) begin
                        word_cnt <= word_cnt + 1'b1;
                        if (word_cnt == WC_W'(BURST - 1)) begin
                            state     <= RUN;
                            load_done <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (core_done) begin
                        state  <= DONE;
                        finish <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Capture banks: word k of the burst lands in state, then goal, then z.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STATE_WORDS; i++) st_q[i] <= '0;
            for (int i = 0; i < GOAL_WORDS; i++)  gl_q[i] <= '0;
            for (int i = 0; i < Z_WORDS; i++)     z_q[i]  <= '0;
        end else if (ld_acc) begin
            for (int i = 0; i < STATE_WORDS; i++)
                if (word_cnt == WC_W'(i)) st_q[i] <= init_data;
            for (int i = 0; i < GOAL_WORDS; i++)
                if (word_cnt == WC_W'(STATE_WORDS + i)) gl_q[i] <= init_data;
            for (int i = 0; i < Z_WORDS; i++)
                if (word_cnt == WC_W'(STATE_WORDS + GOAL_WORDS + i)) z_q[i] <= init_data;
        end
    end

    for (genvar i = 0; i < STATE_WORDS; i++) begin : g_st
        assign state_vec[i*DATA_WIDTH +: DATA_WIDTH] = st_q[i];
    end
    for (genvar i = 0; i < GOAL_WORDS; i++) begin : g_gl
        assign goal_vec[i*DATA_WIDTH +: DATA_WIDTH] = gl_q[i];
    end
    for (genvar i = 0; i < Z_WORDS; i++) begin : g_z
        assign z_vec[i*DATA_WIDTH +: DATA_WIDTH] = z_q[i];
    end

`ifdef CVAE_IO_PERF_EN
    // Run-length counter: counts LOAD and RUN cycles, saturating.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_count <= '0;
        end else if (clr) begin
            cycle_count <= '0;
        end else if (((state == LOAD) || (state == RUN)) && (cycle_count != '1)) begin
            cycle_count <= cycle_count + 1'b1;
        end
    end
`endif

    cvae_io_wr_seq #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .STATE_WORDS(STATE_WORDS),
        .MAX_SEQ    (MAX_SEQ),
        .SEQ_W      (SEQ_W)
    ) u_wr_seq (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .ld_we     (ld_we),
        .ld_addr   (ld_addr),
        .ld_data   (init_data),
        .run_we    (run_we),
        .run_data  (st_data),
        .sram_wea  (sram_state_wea),
        .sram_addr (sram_state_addr),
        .sram_wdata(sram_state_wdata),
        .seq_lens  (seq_lens),
        .overflow  (overflow)
    );

endmodule
